// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Queued, registered ALU opcode sequencer. Opcodes are accepted over a
// valid/ready handshake into a DEPTH-entry circular FIFO. Each one is then
// issued as a one-hot select and held for its latency class.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        synchronous active-low reset
//   op_valid_i    producer has an opcode
//   op_code_i     opcode; only the low 4 bits are decoded, any higher set bit is illegal
//   op_ready_o    FIFO can accept this cycle (combinational)
//   flush_i       synchronous abort of queue and executing op
//   sel_o         registered one-hot ALU select, zero when idle
//   sel_valid_o   sel_o is driving an op
//   op_done_o     one-cycle pulse in the final cycle of an op
//   illegal_o     executing op came from an unmapped opcode
//   fifo_count_o  queued entries, excluding the executing op
module alu_op_sequencer #(
   parameter int unsigned OP_W      = 4,
   parameter int unsigned SEL_W     = 12,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ARITH_LAT = 2,
   parameter int unsigned SHIFT_LAT = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     op_valid_i,
   input  logic [OP_W-1:0]          op_code_i,
   output logic                     op_ready_o,
   input  logic                     flush_i,
   output logic [SEL_W-1:0]         sel_o,
   output logic                     sel_valid_o,
   output logic                     op_done_o,
   output logic                     illegal_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CountW = PtrW + 1;
   localparam int unsigned MaxLat = (ARITH_LAT > SHIFT_LAT) ? ARITH_LAT : SHIFT_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   typedef enum logic [0:0] {StIdle, StExec} state_e;

   state_e              state_q, state_d;
   logic [OP_W-1:0]     mem_q [DEPTH];
   logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CountW-1:0]   count_q, count_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                illegal_q, illegal_d;
   logic                done_q, done_d;
   logic                push, pop;

   logic [OP_W-1:0]     head;
   logic                head_hi;
   logic [SEL_W-1:0]    head_sel;
   logic                head_ill;
   logic [CntW-1:0]     head_lat_m1;

   assign op_ready_o = (count_q < CountW'(DEPTH)) && !flush_i && rst_ni;
   assign push       = op_valid_i && op_ready_o;

   // Decode of the FIFO head; the loaded counter value is latency minus one.
   assign head = mem_q[rptr_q];

   always_comb begin
      head_hi     = 1'b0;
      head_sel    = '0;
      head_ill    = 1'b0;
      head_lat_m1 = '0;
      for (int i = 4; i < OP_W; i++) begin
         head_hi = head_hi | head[i];
      end
      if (head_hi) begin
         head_sel[11] = 1'b1;
         head_ill     = 1'b1;
      end else begin
         case (head[3:0])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: head_sel = SEL_W'(1) << head[2:0];
            4'h8: begin
               head_sel[7] = 1'b1;
               head_lat_m1 = CntW'(ARITH_LAT - 1);
            end
            4'h9: begin
               head_sel[8] = 1'b1;
               head_lat_m1 = CntW'(ARITH_LAT - 1);
            end
            4'hA: begin
               head_sel[9] = 1'b1;
               head_lat_m1 = CntW'(SHIFT_LAT - 1);
            end
            4'hB: begin
               head_sel[10] = 1'b1;
               head_lat_m1  = CntW'(SHIFT_LAT - 1);
            end
            4'hF: head_sel[11] = 1'b1;
            default: begin
               head_sel[11] = 1'b1;
               head_ill     = 1'b1;
            end
         endcase
      end
   end

   // Next-state: flush overrides everything, then issue/countdown, then FIFO bookkeeping.
   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      pop       = 1'b0;

      if (flush_i) begin
         state_d   = StIdle;
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         cnt_d     = '0;
         sel_d     = '0;
         illegal_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (count_q != '0) pop = 1'b1;
            end
            StExec: begin
               if (cnt_q != '0) begin
                  cnt_d  = cnt_q - 1'b1;
                  done_d = (cnt_q == CntW'(1));
               end else if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d   = StIdle;
                  sel_d     = '0;
                  illegal_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase

         if (pop) begin
            state_d   = StExec;
            sel_d     = head_sel;
            illegal_d = head_ill;
            cnt_d     = head_lat_m1;
            done_d    = (head_lat_m1 == '0);
            rptr_d    = rptr_q + 1'b1;
         end

         if (push) wptr_d = wptr_q + 1'b1;

         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         cnt_q     <= '0;
         sel_q     <= '0;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         illegal_q <= illegal_d;
         done_q    <= done_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= op_code_i;
   end

   assign sel_o        = sel_q;
   assign sel_valid_o  = (state_q == StExec);
   assign op_done_o    = done_q;
   assign illegal_o    = illegal_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

   localparam int unsigned OpW   = 6;
   localparam int unsigned SelW  = 12;
   localparam int unsigned Depth = 4;
   localparam int unsigned ALat  = 2;
   localparam int unsigned SLat  = 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   op_valid;
   logic [OpW-1:0]         op_code;
   logic                   flush;
   logic                   op_ready;
   logic [SelW-1:0]        sel;
   logic                   sel_valid;
   logic                   op_done;
   logic                   illegal;
   logic [$clog2(Depth):0] fifo_count;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .OP_W      (OpW),
      .SEL_W     (SelW),
      .DEPTH     (Depth),
      .ARITH_LAT (ALat),
      .SHIFT_LAT (SLat)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .op_valid_i   (op_valid),
      .op_code_i    (op_code),
      .op_ready_o   (op_ready),
      .flush_i      (flush),
      .sel_o        (sel),
      .sel_valid_o  (sel_valid),
      .op_done_o    (op_done),
      .illegal_o    (illegal),
      .fifo_count_o (fifo_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending opcodes plus the executing op.
   int q[$];
   bit busy = 1'b0;
   int cur  = 0;
   int rem  = 0;
   bit last_acc;
   int done_cnt, ill_cnt, max_cnt;

   // Select bit per 4-bit opcode; -1 marks unmapped codes.
   int bit_tab[16] = '{0, 1, 2, 3, 4, 5, 6, -1, 7, 8, 9, 10, -1, -1, -1, 11};
   int sweep[12]   = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 15};
   int bad[5]      = '{7, 12, 13, 14, 16};

   function automatic bit is_illegal(int c);
      return (c > 15) || (bit_tab[c] < 0);
   endfunction

   function automatic int sel_bit(int c);
      if (is_illegal(c)) return 11;
      return bit_tab[c];
   endfunction

   function automatic int lat_of(int c);
      int b;
      b = sel_bit(c);
      if (is_illegal(c)) return 1;
      if (b == 7 || b == 8) return ALat;
      if (b == 9 || b == 10) return SLat;
      return 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check op_ready, advance model at posedge, check outputs.
   task automatic step(input bit v, input int c, input bit f, input bit r);
      bit ready;
      int exp_sel;
      op_valid = v;
      op_code  = OpW'(c);
      flush    = f;
      rst_n    = r;
      #1;
      ready = r && !f && (q.size() < Depth);
      chk("op_ready", 32'(op_ready), 32'(ready));
      last_acc = v && ready;
      @(posedge clk);
      if (!r || f) begin
         q.delete();
         busy = 1'b0;
      end else begin
         if (busy && rem > 1) begin
            rem--;
         end else if (q.size() > 0) begin
            cur  = q.pop_front();
            rem  = lat_of(cur);
            busy = 1'b1;
         end else begin
            busy = 1'b0;
         end
         if (last_acc) q.push_back(c % 64);
      end
      #1;
      exp_sel = busy ? (1 << sel_bit(cur)) : 0;
      chk("sel_valid", 32'(sel_valid), 32'(busy));
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("illegal", 32'(illegal), 32'(busy && is_illegal(cur)));
      chk("op_done", 32'(op_done), 32'(busy && rem == 1));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      if (op_done) done_cnt++;
      if (illegal) ill_cnt++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      @(negedge clk);
   endtask

   initial begin
      int idx, guard;
      op_valid = 1'b0;
      op_code  = '0;
      flush    = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);

      // Reset held with a valid opcode offered, then release.
      repeat (3) step(1'b1, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);

      // Legal decode sweep, back-to-back.
      done_cnt = 0;
      ill_cnt  = 0;
      idx      = 0;
      guard    = 0;
      while (idx < 12 && guard < 100) begin
         step(1'b1, sweep[idx], 1'b0, 1'b1);
         if (last_acc) idx++;
         guard++;
      end
      chk("sweep_accepted", 32'(idx), 32'd12);
      repeat (12) step(1'b0, 0, 1'b0, 1'b1);
      chk("sweep_done_count", 32'(done_cnt), 32'd12);
      chk("sweep_illegal_cycles", 32'(ill_cnt), 32'd0);

      // Illegal opcodes, each in isolation.
      foreach (bad[i]) begin
         done_cnt = 0;
         ill_cnt  = 0;
         step(1'b1, bad[i], 1'b0, 1'b1);
         repeat (3) step(1'b0, 0, 1'b0, 1'b1);
         chk("illegal_cycles", 32'(ill_cnt), 32'd1);
         chk("illegal_done", 32'(done_cnt), 32'd1);
      end

      // Backpressure: continuous ADDs fill the FIFO, incl. pop while full and offered.
      done_cnt = 0;
      max_cnt  = 0;
      idx      = 0;
      guard    = 0;
      while (idx < 8 && guard < 100) begin
         step(1'b1, 8, 1'b0, 1'b1);
         if (last_acc) idx++;
         guard++;
      end
      chk("full_accepted", 32'(idx), 32'd8);
      chk("full_max_count", 32'(max_cnt), 32'(Depth));
      repeat (20) step(1'b0, 0, 1'b0, 1'b1);
      chk("full_done_count", 32'(done_cnt), 32'd8);

      // Flush in the final ADD cycle with two ops queued.
      step(1'b1, 8, 1'b0, 1'b1);
      step(1'b1, 0, 1'b0, 1'b1);
      step(1'b1, 1, 1'b0, 1'b1);
      chk("flush_pre_queued", 32'(fifo_count), 32'd2);
      done_cnt = 0;
      step(1'b0, 0, 1'b1, 1'b1);
      repeat (4) step(1'b0, 0, 1'b0, 1'b1);
      chk("flush_no_issue", 32'(done_cnt), 32'd0);

      // Randomised traffic with occasional flush and reset.
      repeat (400) begin
         int c;
         c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                         : int'($urandom_range(0, 15));
         step($urandom_range(0, 3) != 0, c, $urandom_range(0, 39) == 0,
              $urandom_range(0, 79) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
